// File: rtl/work_ram_pkg.sv
// Shared types and sizes for the work RAM arbiter.
package work_ram_pkg;

  localparam int unsigned WR_AW = 13;
  localparam int unsigned WR_DW = 8;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

endpackage

// File: rtl/work_ram_arbiter.sv
// Two-port arbiter in front of the single-port work RAM: zero-fills after reset,
// then grants one access per cycle, port A first, with a bounded wait for port B.
module work_ram_arbiter
  import work_ram_pkg::*;
#(
  parameter int unsigned AW       = WR_AW,
  parameter int unsigned DW       = WR_DW,
  parameter int unsigned MAX_WAIT = 4,
  parameter bit          CLEAR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_reset,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WaitMax = CW'(MAX_WAIT);
  localparam state_e StReset = CLEAR_EN ? ST_CLEAR : ST_RUN;

  state_e        state_q, state_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          b_force;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StReset;
      rd_owner_q <= OWN_NONE;
      clr_addr_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      clr_addr_q <= clr_addr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_owner_d = OWN_NONE;
    clr_addr_d = clr_addr_q;
    wait_cnt_d = wait_cnt_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    ram_ce     = 1'b0;
    ram_wre    = 1'b0;
    ram_ad     = a_addr;
    ram_din    = a_wdata;
    b_force    = b_req & (wait_cnt_q == WaitMax);

    unique case (state_q)
      ST_CLEAR: begin
        ram_ce     = 1'b1;
        ram_wre    = 1'b1;
        ram_din    = '0;
        ram_ad     = clr_addr_q;
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        b_gnt = b_req & (~a_req | b_force);
        a_gnt = a_req & ~b_gnt;
        if (b_gnt) begin
          ram_ce     = 1'b1;
          ram_wre    = b_we;
          ram_ad     = b_addr;
          ram_din    = b_wdata;
          rd_owner_d = b_we ? OWN_NONE : OWN_B;
        end else if (a_gnt) begin
          ram_ce     = 1'b1;
          ram_wre    = a_we;
          rd_owner_d = a_we ? OWN_NONE : OWN_A;
        end
      end
      default: state_d = StReset;
    endcase

    if (!b_req || b_gnt) begin
      wait_cnt_d = '0;
    end else if (a_gnt && wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Nothing reaches the RAM or the requesters while reset is held.
    if (!reset_n) begin
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      ram_ce  = 1'b0;
      ram_wre = 1'b0;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign a_rvalid  = (rd_owner_q == OWN_A);
  assign b_rvalid  = (rd_owner_q == OWN_B);
  assign a_rdata   = a_rvalid ? ram_dout : '0;
  assign b_rdata   = b_rvalid ? ram_dout : '0;

endmodule
